e_mdu: RTL and testbench



---
 rtl/e_mdu_if.sv | 14 +
 rtl/e_mdu.sv | 143 ++++++++++++++
 tb/tb_e_mdu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E-stage issue logic and the multiply/divide unit.
// master = issuing pipeline stage, slave = e_mdu.
interface e_mdu_if;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, mdu_op, A, B, input busy, HI, LO);
   modport slave  (input start, mdu_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div, single-cycle mthi/mtlo.
// Optional accumulate ops (madd/maddu/msub/msubu) are built only when MDU_MADD_EN is defined.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic    clk,
   input  logic    reset,
   e_mdu_if.slave  bus
);
   // Handshake: start is a one-cycle pulse sampled on the rising edge; it is accepted only
   // when busy is low and the op is legal, otherwise it is dropped. busy is high for exactly
   // the op's cycle count, and HI/LO update on the same edge busy falls.
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;

   logic [63:0]        prod_s, prod_u;
   logic [31:0]        b_safe;
   logic signed [31:0] quot_s, rem_s;
   logic [31:0]        quot_u, rem_u;

   assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
   assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

   // Divisor forced nonzero so the unused quotient never goes X; B=0 selects HI/LO instead.
   assign b_safe = (bus.B == 32'd0) ? 32'd1 : bus.B;
   assign quot_s = $signed(bus.A) / $signed(b_safe);
   assign rem_s  = $signed(bus.A) % $signed(b_safe);
   assign quot_u = bus.A / b_safe;
   assign rem_u  = bus.A % b_safe;

`ifdef MDU_MADD_EN
   logic [63:0] acc_base;
   assign acc_base = {hi_q, lo_q};
`endif

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      thi_d  = thi_q;
      tlo_d  = tlo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (busy_q) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            hi_d   = thi_q;
            lo_d   = tlo_q;
            busy_d = 1'b0;
         end
      end else if (bus.start) begin
         case (bus.mdu_op)
            OP_MULT: begin
               {thi_d, tlo_d} = prod_s;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
            OP_MULTU: begin
               {thi_d, tlo_d} = prod_u;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
            OP_DIV: begin
               if (bus.B != 32'd0) {thi_d, tlo_d} = {32'(rem_s), 32'(quot_s)};
               else                {thi_d, tlo_d} = {hi_q, lo_q};
               cnt_d  = DIV_CNT;
               busy_d = 1'b1;
            end
            OP_DIVU: begin
               if (bus.B != 32'd0) {thi_d, tlo_d} = {rem_u, quot_u};
               else                {thi_d, tlo_d} = {hi_q, lo_q};
               cnt_d  = DIV_CNT;
               busy_d = 1'b1;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
               {thi_d, tlo_d} = acc_base + prod_s;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
            OP_MADDU: begin
               {thi_d, tlo_d} = acc_base + prod_u;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
            OP_MSUB: begin
               {thi_d, tlo_d} = acc_base - prod_s;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
            OP_MSUBU: begin
               {thi_d, tlo_d} = acc_base - prod_u;
               cnt_d  = MULT_CNT;
               busy_d = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         thi_q  <= 32'd0;
         tlo_q  <= 32'd0;
         cnt_q  <= 4'd0;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         thi_q  <= thi_d;
         tlo_q  <= tlo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, results, ignored starts, divide-by-zero, async reset abort,
// and the MDU_MADD_EN accumulate ops (or their rejection when the macro is undefined).
module tb_e_mdu;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; start is seen on the next edge, returns at that edge +1.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start  = 1'b1;
      bus.mdu_op = op;
      bus.A      = a;
      bus.B      = b;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.mdu_op = 4'd0;
   endtask

   // Checks n busy cycles with HI/LO held, optionally firing a stray mult at cycle inj.
   task automatic run_busy(input string tag, input int n, input int inj,
                           input logic [31:0] hi_old, input logic [31:0] lo_old);
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, 32'(bus.busy), 32'd1);
         chk({tag, " hi_hold"}, bus.HI, hi_old);
         chk({tag, " lo_hold"}, bus.LO, lo_old);
         if (i == inj) begin
            bus.start  = 1'b1;
            bus.mdu_op = 4'd1;
            bus.A      = 32'd5;
            bus.B      = 32'd5;
         end
         @(posedge clk);
         #1;
         bus.start  = 1'b0;
         bus.mdu_op = 4'd0;
      end
      chk({tag, " busy_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst hi", bus.HI, 32'd0);
      chk("rst lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      bus.start  = 1'b0;
      bus.mdu_op = 4'd0;
      bus.A      = 32'd0;
      bus.B      = 32'd0;
      @(posedge clk);
      do_reset();

      // mult 3 * -2 = -6
      issue(4'd1, 32'd3, 32'hFFFF_FFFE);
      run_busy("mult", 5, -1, 32'd0, 32'd0);
      chk("mult hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult lo", bus.LO, 32'hFFFF_FFFA);

      // multu 0xFFFFFFFF * 2, stray start during busy must be dropped
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      run_busy("multu", 5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      chk("multu hi", bus.HI, 32'h0000_0001);
      chk("multu lo", bus.LO, 32'hFFFF_FFFE);
      @(posedge clk);
      #1;
      chk("multu no_extend", 32'(bus.busy), 32'd0);
      chk("multu hi_stable", bus.HI, 32'h0000_0001);

      // div -7 / 2 = -3 rem -1
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      run_busy("div", 10, -1, 32'h0000_0001, 32'hFFFF_FFFE);
      chk("div hi", bus.HI, 32'hFFFF_FFFF);
      chk("div lo", bus.LO, 32'hFFFF_FFFD);

      // divu 7 / 2 = 3 rem 1
      issue(4'd4, 32'd7, 32'd2);
      run_busy("divu", 10, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      chk("divu hi", bus.HI, 32'd1);
      chk("divu lo", bus.LO, 32'd3);

      // Reset mid-division: abort with no later commit
      issue(4'd3, 32'd100, 32'd7);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
      end
      chk("abort pre busy", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort hi", bus.HI, 32'd0);
      chk("abort lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
      end
      chk("abort late busy", 32'(bus.busy), 32'd0);
      chk("abort late hi", bus.HI, 32'd0);
      chk("abort late lo", bus.LO, 32'd0);

      // mthi is single-cycle
      issue(4'd5, 32'h1234_5678, 32'd0);
      chk("mthi busy", 32'(bus.busy), 32'd0);
      chk("mthi hi", bus.HI, 32'h1234_5678);
      chk("mthi lo", bus.LO, 32'd0);

      // divu by zero keeps HI/LO but still takes the full latency
      issue(4'd4, 32'd5, 32'd0);
      run_busy("div0", 10, -1, 32'h1234_5678, 32'd0);
      chk("div0 hi", bus.HI, 32'h1234_5678);
      chk("div0 lo", bus.LO, 32'd0);

      // Illegal op 11 is ignored
      issue(4'd11, 32'd9, 32'd9);
      chk("illegal busy", 32'(bus.busy), 32'd0);
      chk("illegal hi", bus.HI, 32'h1234_5678);

      @(posedge clk);
      #1;
      do_reset();
      issue(4'd6, 32'h0000_000A, 32'd0);
      chk("mtlo lo", bus.LO, 32'h0000_000A);
      chk("mtlo busy", 32'(bus.busy), 32'd0);
`ifdef MDU_MADD_EN
      // madd: {0, 0xA} + 2*3 = 0x10
      issue(4'd7, 32'd2, 32'd3);
      run_busy("madd", 5, -1, 32'd0, 32'h0000_000A);
      chk("madd hi", bus.HI, 32'd0);
      chk("madd lo", bus.LO, 32'h0000_0010);
      // msubu: {0, 0xA} - 1*11 = -1
      issue(4'd6, 32'h0000_000A, 32'd0);
      issue(4'd10, 32'd1, 32'd11);
      run_busy("msubu", 5, -1, 32'd0, 32'h0000_000A);
      chk("msubu hi", bus.HI, 32'hFFFF_FFFF);
      chk("msubu lo", bus.LO, 32'hFFFF_FFFF);
`else
      issue(4'd7, 32'd2, 32'd3);
      chk("madd off busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
      end
      chk("madd off hi", bus.HI, 32'd0);
      chk("madd off lo", bus.LO, 32'h0000_000A);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
